// File: rtl/xinyi_trace_pkg.sv
// -----------------------------------------------------------------------------
// xinyi_trace_pkg
//
// Shared types for the writeback debug-trace path.
//   wb_trace_entry_t : one retired register write as carried through the
//                      trace FIFO (pc, destination register, write data).
//   TRACE_WEN_ALL    : byte-enable pattern driven on debug_wb_rf_wen while a
//                      write is being replayed.
//   TRACE_WEN_NONE   : byte-enable pattern while idle.
// -----------------------------------------------------------------------------
package xinyi_trace_pkg;

   localparam logic [3:0] TRACE_WEN_ALL  = 4'hf;
   localparam logic [3:0] TRACE_WEN_NONE = 4'h0;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [31:0] wdata;
   } wb_trace_entry_t;

endpackage : xinyi_trace_pkg

// File: rtl/wb_trace_fifo.sv
// -----------------------------------------------------------------------------
// wb_trace_fifo
//
// Two-write / one-read circular buffer of wb_trace_entry_t.
//
// Ports:
//   clk, resetn      : clock, synchronous active-low reset (pointers only)
//   push[1:0]        : write mask; bit 0 writes entry0, bit 1 writes entry1
//   entry0, entry1   : entries to store; entry0 is older than entry1
//   pop              : remove the head entry this cycle
//   head             : oldest stored entry (meaningful only when count != 0)
//   count            : number of stored entries, 0..DEPTH
//
// The caller guarantees that the number of set push bits never exceeds the
// free space and that pop is only asserted when count != 0.
// -----------------------------------------------------------------------------
module wb_trace_fifo
   import xinyi_trace_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [1:0]             push,
   input  wb_trace_entry_t        entry0,
   input  wb_trace_entry_t        entry1,
   input  logic                   pop,
   output wb_trace_entry_t        head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   wb_trace_entry_t mem [DEPTH];

   // One extra pointer bit distinguishes full from empty with natural wrap.
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] slot1_ptr;
   logic [PW-1:0] push_cnt;

   // NOTE: every variable written here gets a value before any condition,
   // so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      push_cnt  = PW'(push[0]) + PW'(push[1]);
      // entry1 lands right behind entry0 when both push, otherwise it takes
      // wr_ptr itself so a lone ch1 write stays contiguous.
      slot1_ptr = wr_ptr + PW'(push[0]);
   end

   // NOTE: sequential state is updated with non-blocking assignments so all
   // registers sample pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_ptr + push_cnt;
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

   // NOTE: the storage array is deliberately left out of reset; stale slots
   // are unreachable because the pointers define which entries are valid.
   always_ff @(posedge clk) begin
      if (push[0]) begin
         mem[wr_ptr[AW-1:0]] <= entry0;
      end
      if (push[1]) begin
         mem[slot1_ptr[AW-1:0]] <= entry1;
      end
   end

   assign count = wr_ptr - rd_ptr;
   assign head  = mem[rd_ptr[AW-1:0]];

endmodule : wb_trace_fifo

// File: rtl/wb_trace_serializer.sv
// -----------------------------------------------------------------------------
// wb_trace_serializer
//
// Debug-trace stage between the dual-issue writeback stage and the SoC
// debug_wb_* ports. Up to two retired register writes per cycle (channel 0
// older than channel 1) are filtered, buffered and replayed in program order
// one per cycle on the single-issue debug interface.
//
// Ports:
//   clk, resetn              : clock, synchronous active-low reset
//   wb0_*/wb1_*              : writeback channels (en, rd, wdata, pc)
//   retire_num[1:0]          : instructions retired this cycle (0..2)
//   in_ready                 : at least two FIFO slots free; producer stalls
//                              while low
//   debug_wb_pc/rf_wen/
//   rf_wnum/rf_wdata         : replayed write, all zeros when idle
//   overflow                 : sticky, set by a push arriving while
//                              in_ready is low
//   retire_cnt[31:0]         : retired-instruction count (only when the
//                              macro WB_TRACE_CNT_EN is defined)
//
// Configuration macro: WB_TRACE_CNT_EN adds the retire counter and its port;
// without it retire_num is ignored.
// -----------------------------------------------------------------------------
module wb_trace_serializer
   import xinyi_trace_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        wb0_en,
   input  logic [4:0]  wb0_rd,
   input  logic [31:0] wb0_wdata,
   input  logic [31:0] wb0_pc,
   input  logic        wb1_en,
   input  logic [4:0]  wb1_rd,
   input  logic [31:0] wb1_wdata,
   input  logic [31:0] wb1_pc,
   input  logic [1:0]  retire_num,
   output logic        in_ready,
   output logic [31:0] debug_wb_pc,
   output logic [3:0]  debug_wb_rf_wen,
   output logic [4:0]  debug_wb_rf_wnum,
   output logic [31:0] debug_wb_rf_wdata,
   output logic        overflow
`ifdef WB_TRACE_CNT_EN
   ,
   output logic [31:0] retire_cnt
`endif
);

   localparam int PW = $clog2(DEPTH) + 1;

   wb_trace_entry_t entry0;
   wb_trace_entry_t entry1;
   wb_trace_entry_t head;
   logic [PW-1:0]   count;
   logic [PW-1:0]   free_slots;
   logic            q0;
   logic            q1;
   logic [1:0]      push;
   logic            valid;

   // Writes to $0 are architectural no-ops and never reach the trace.
   assign q0 = wb0_en && (wb0_rd != 5'd0);
   assign q1 = wb1_en && (wb1_rd != 5'd0);

   assign entry0 = '{pc: wb0_pc, rd: wb0_rd, wdata: wb0_wdata};
   assign entry1 = '{pc: wb1_pc, rd: wb1_rd, wdata: wb1_wdata};

   assign free_slots = PW'(DEPTH) - count;
   assign in_ready   = (free_slots >= PW'(2));
   assign valid      = (count != '0);

   // Free space is judged on the registered count only; the slot released by
   // this cycle's pop is not reused until the next cycle.
   always_comb begin
      push = {q1, q0};
      if (free_slots == '0) begin
         push = 2'b00;
      end else if ((free_slots == PW'(1)) && q0) begin
         // Only one slot left: the older channel keeps it.
         push = 2'b01;
      end
   end

   wb_trace_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (push),
      .entry0 (entry0),
      .entry1 (entry1),
      .pop    (valid),
      .head   (head),
      .count  (count)
   );

   // The head is shown straight from storage; zero-masking keeps stale
   // slot contents off the debug port while the FIFO is empty.
   assign debug_wb_pc       = valid ? head.pc    : 32'd0;
   assign debug_wb_rf_wnum  = valid ? head.rd    : 5'd0;
   assign debug_wb_rf_wdata = valid ? head.wdata : 32'd0;
   assign debug_wb_rf_wen   = valid ? TRACE_WEN_ALL : TRACE_WEN_NONE;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         overflow <= 1'b0;
      end else if ((q0 || q1) && !in_ready) begin
         overflow <= 1'b1;
      end
   end

`ifdef WB_TRACE_CNT_EN
   always_ff @(posedge clk) begin
      if (!resetn) begin
         retire_cnt <= 32'd0;
      end else begin
         retire_cnt <= retire_cnt + 32'(retire_num);
      end
   end
`else
   logic retire_num_unused;
   assign retire_num_unused = ^retire_num;
`endif

endmodule : wb_trace_serializer

// File: tb/tb_wb_trace_serializer.sv
// -----------------------------------------------------------------------------
// tb_wb_trace_serializer
//
// Self-checking bench for wb_trace_serializer. Expected writes are queued in
// program order when the stimulus is driven (respecting the free space the
// FIFO had at that moment) and retired from the queue as the DUT replays them.
// Outputs are sampled 1 time unit after the rising edge; inputs change there
// as well. Covers retire_cnt when WB_TRACE_CNT_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_trace_serializer;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        resetn;
   logic        wb0_en, wb1_en;
   logic [4:0]  wb0_rd, wb1_rd;
   logic [31:0] wb0_wdata, wb1_wdata, wb0_pc, wb1_pc;
   logic [1:0]  retire_num;
   logic        in_ready;
   logic [31:0] debug_wb_pc;
   logic [3:0]  debug_wb_rf_wen;
   logic [4:0]  debug_wb_rf_wnum;
   logic [31:0] debug_wb_rf_wdata;
   logic        overflow;
`ifdef WB_TRACE_CNT_EN
   logic [31:0] retire_cnt;
   logic [31:0] exp_retire;
`endif

   always #5 clk = ~clk;

   wb_trace_serializer #(.DEPTH(DEPTH)) dut (
      .clk               (clk),
      .resetn            (resetn),
      .wb0_en            (wb0_en),
      .wb0_rd            (wb0_rd),
      .wb0_wdata         (wb0_wdata),
      .wb0_pc            (wb0_pc),
      .wb1_en            (wb1_en),
      .wb1_rd            (wb1_rd),
      .wb1_wdata         (wb1_wdata),
      .wb1_pc            (wb1_pc),
      .retire_num        (retire_num),
      .in_ready          (in_ready),
      .debug_wb_pc       (debug_wb_pc),
      .debug_wb_rf_wen   (debug_wb_rf_wen),
      .debug_wb_rf_wnum  (debug_wb_rf_wnum),
      .debug_wb_rf_wdata (debug_wb_rf_wdata),
      .overflow          (overflow)
`ifdef WB_TRACE_CNT_EN
      ,
      .retire_cnt        (retire_cnt)
`endif
   );

   // Debug port flattened as {pc, wnum, wdata, wen}.
   wire [72:0] dbg = {debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata, debug_wb_rf_wen};

   // Scoreboard: {pc, rd, wdata} of every write the DUT should replay.
   logic [68:0] sb [$];
   bit          pop_due;
   bit          pend_ovf;
   logic        exp_ovf;
   logic [72:0] exp_out;
   logic        exp_rdy;
   int          n_cmp;
   int          n_bad;

   // Drive one cycle of writeback traffic and queue what should be kept.
   task automatic drive(input logic e0, input logic [4:0] r0, input logic [31:0] d0,
                        input logic [31:0] p0, input logic e1, input logic [4:0] r1,
                        input logic [31:0] d1, input logic [31:0] p1, input logic [1:0] rn);
      int free;
      bit q0, q1;
      wb0_en = e0; wb0_rd = r0; wb0_wdata = d0; wb0_pc = p0;
      wb1_en = e1; wb1_rd = r1; wb1_wdata = d1; wb1_pc = p1;
      retire_num = rn;
      free = DEPTH - sb.size();
      q0 = e0 && (r0 != 5'd0);
      q1 = e1 && (r1 != 5'd0);
      if ((q0 || q1) && free < 2) pend_ovf = 1'b1;
      if (q0 && free > 0) begin
         sb.push_back({p0, r0, d0});
         free--;
      end
      if (q1 && free > 0) sb.push_back({p1, r1, d1});
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 2'd0);
   endtask

   // Advance one clock and update the reference state.
   task automatic tick();
      @(posedge clk);
      if (!resetn) begin
         sb.delete();
         exp_ovf = 1'b0;
`ifdef WB_TRACE_CNT_EN
         exp_retire = 32'd0;
`endif
      end else begin
         if (pop_due) void'(sb.pop_front());
         if (pend_ovf) exp_ovf = 1'b1;
`ifdef WB_TRACE_CNT_EN
         exp_retire = exp_retire + 32'(retire_num);
`endif
      end
      pend_ovf = 1'b0;
      #1;
      pop_due = (sb.size() != 0);
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      idle();
      repeat (3) tick();
      resetn = 1'b1;
      for (int c = 0; c < 2; c++) begin
         n_cmp++;
         if (dbg !== 73'd0) begin
            n_bad++; $display("FAIL reset_dbg c%0d: got %h want 0", c, dbg);
         end
         n_cmp++;
         if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_in_ready c%0d: got %b want 1", c, in_ready);
         end
         n_cmp++;
         if (overflow !== 1'b0) begin
            n_bad++; $display("FAIL reset_overflow c%0d: got %b want 0", c, overflow);
         end
`ifdef WB_TRACE_CNT_EN
         n_cmp++;
         if (retire_cnt !== 32'd0) begin
            n_bad++; $display("FAIL reset_retire_cnt c%0d: got %h want 0", c, retire_cnt);
         end
`endif
         tick();
      end
   endtask

   task automatic test_dual_push();
      drive(1'b1, 5'd2, 32'h1111_1111, 32'hbfc0_0000,
            1'b1, 5'd3, 32'h2222_2222, 32'hbfc0_0004, 2'd2);
      tick();
      idle();
      // Two replayed writes, then idle zeros.
      for (int c = 0; c < 3; c++) begin
         exp_out = (sb.size() != 0) ? {sb[0], 4'hf} : 73'd0;
         n_cmp++;
         if (dbg !== exp_out) begin
            n_bad++; $display("FAIL dual_out c%0d: got %h want %h", c, dbg, exp_out);
         end
         tick();
      end
   endtask

   task automatic test_filter();
      drive(1'b1, 5'd0, 32'h3333_3333, 32'hbfc0_0008,
            1'b0, 5'd5, 32'h4444_4444, 32'hbfc0_000c, 2'd2);
      tick();
      idle();
      for (int c = 0; c < 2; c++) begin
         n_cmp++;
         if (dbg !== 73'd0) begin
            n_bad++; $display("FAIL filter_out c%0d: got %h want 0", c, dbg);
         end
         tick();
      end
`ifdef WB_TRACE_CNT_EN
      n_cmp++;
      if (retire_cnt !== exp_retire) begin
         n_bad++; $display("FAIL filter_retire_cnt: got %0d want %0d", retire_cnt, exp_retire);
      end
`endif
   endtask

   task automatic test_fill_wrap();
      int  pushes = 0;
      bit  saw_low = 1'b0;
      int  c = 0;
      while ((pushes < 7 || sb.size() != 0) && c < 60) begin
         exp_out = (sb.size() != 0) ? {sb[0], 4'hf} : 73'd0;
         exp_rdy = (DEPTH - sb.size()) >= 2;
         n_cmp++;
         if (dbg !== exp_out) begin
            n_bad++; $display("FAIL fill_out c%0d: got %h want %h", c, dbg, exp_out);
         end
         n_cmp++;
         if (in_ready !== exp_rdy) begin
            n_bad++; $display("FAIL fill_in_ready c%0d: got %b want %b", c, in_ready, exp_rdy);
         end
         if (!in_ready) saw_low = 1'b1;
         if (pushes < 7 && in_ready) begin
            drive(1'b1, 5'(2 * pushes + 1), $urandom, 32'h8000_0000 + 32'(pushes * 8),
                  1'b1, 5'(2 * pushes + 2), $urandom, 32'h8000_0004 + 32'(pushes * 8), 2'd2);
            pushes++;
         end else begin
            idle();
         end
         tick();
         c++;
      end
      n_cmp++;
      if (pushes != 7 || sb.size() != 0) begin
         n_bad++; $display("FAIL fill_timeout: got pushes %0d left %0d want 7 and 0", pushes, sb.size());
      end
      n_cmp++;
      if (saw_low !== 1'b1) begin
         n_bad++; $display("FAIL fill_in_ready_drop: got %b want 1", saw_low);
      end
      n_cmp++;
      if (overflow !== 1'b0) begin
         n_bad++; $display("FAIL fill_overflow: got %b want 0", overflow);
      end
   endtask

   task automatic test_overflow();
      int c = 0;
      // Fill to exactly one free slot while in_ready still permits pushes.
      while (sb.size() < DEPTH - 1 && c < 20) begin
         drive(1'b1, 5'(c + 1), $urandom, 32'h9000_0000 + 32'(c * 8),
               1'b1, 5'(c + 10), $urandom, 32'h9000_0004 + 32'(c * 8), 2'd2);
         tick();
         c++;
      end
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_bad++; $display("FAIL ovf_in_ready: got %b want 0", in_ready);
      end
      // Forced dual push with one free slot: only ch0 may be kept.
      drive(1'b1, 5'd7, 32'haaaa_0007, 32'ha000_0000,
            1'b1, 5'd8, 32'hbbbb_0008, 32'ha000_0004, 2'd2);
      tick();
      idle();
      c = 0;
      while (c < 20) begin
         exp_out = (sb.size() != 0) ? {sb[0], 4'hf} : 73'd0;
         n_cmp++;
         if (dbg !== exp_out) begin
            n_bad++; $display("FAIL ovf_out c%0d: got %h want %h", c, dbg, exp_out);
         end
         n_cmp++;
         if (overflow !== exp_ovf) begin
            n_bad++; $display("FAIL ovf_sticky c%0d: got %b want %b", c, overflow, exp_ovf);
         end
         if (sb.size() == 0) break;
         tick();
         c++;
      end
      n_cmp++;
      if (overflow !== 1'b1) begin
         n_bad++; $display("FAIL ovf_hold: got %b want 1", overflow);
      end
   endtask

   task automatic test_midstream_reset();
      int c = 0;
      while (sb.size() < 5 && c < 20) begin
         drive(1'b1, 5'(c + 3), $urandom, 32'hc000_0000 + 32'(c * 8),
               1'b1, 5'(c + 20), $urandom, 32'hc000_0004 + 32'(c * 8), 2'd2);
         tick();
         c++;
      end
      n_cmp++;
      if (sb.size() != 5) begin
         n_bad++; $display("FAIL mid_queued: got %0d want 5", sb.size());
      end
      idle();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      n_cmp++;
      if (overflow !== 1'b0) begin
         n_bad++; $display("FAIL mid_overflow: got %b want 0", overflow);
      end
`ifdef WB_TRACE_CNT_EN
      n_cmp++;
      if (retire_cnt !== 32'd0) begin
         n_bad++; $display("FAIL mid_retire_cnt: got %0d want 0", retire_cnt);
      end
`endif
      // Nothing stale may appear, then one fresh pair must flow normally.
      for (int k = 0; k < 6; k++) begin
         exp_out = (sb.size() != 0) ? {sb[0], 4'hf} : 73'd0;
         n_cmp++;
         if (dbg !== exp_out) begin
            n_bad++; $display("FAIL mid_out c%0d: got %h want %h", k, dbg, exp_out);
         end
         n_cmp++;
         if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL mid_in_ready c%0d: got %b want 1", k, in_ready);
         end
         if (k == 3) begin
            drive(1'b1, 5'd30, 32'hdead_0030, 32'hd000_0000,
                  1'b1, 5'd31, 32'hdead_0031, 32'hd000_0004, 2'd2);
         end else begin
            idle();
         end
         tick();
      end
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++; $display("FAIL mid_drain: got %0d left want 0", sb.size());
      end
   endtask

   initial begin
      n_cmp    = 0;
      n_bad    = 0;
      pop_due  = 1'b0;
      pend_ovf = 1'b0;
      exp_ovf  = 1'b0;
`ifdef WB_TRACE_CNT_EN
      exp_retire = 32'd0;
`endif
      resetn = 1'b0;
      idle();
      test_reset();
      test_dual_push();
      test_filter();
      test_fill_wrap();
      test_overflow();
      test_midstream_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_wb_trace_serializer
